hazard_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage CPU.
- Detects the hazards that EX-stage forwarding cannot resolve:
  - load-use;
  - multi-cycle EX operations (MUL/DIV);
  - memory wait from the IM/DM bus wrappers;
  - taken-branch/jump redirects.
- Drives per-stage register write-enables and flushes.
- Sits beside the forwarding unit in the CPU top. It uses the same ID/EX register-address fields and provides performance counters.

---
 rtl/hazard_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for load-use, multi-cycle EX ops, memory wait and redirects.
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             EX_redirect,
  input  logic             EX_mc_start,
  input  logic             IM_busy,
  input  logic             DM_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {INIT, RUN, MC_WAIT} state_t;
  localparam int MCW = $clog2(MC_LAT + 1);
  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB write; IF_ID, ID_EX, EX_MEM flush}
  localparam logic [7:0] C_ALL  = 8'b11111_000;
  localparam logic [7:0] C_INIT = 8'b00000_110;
  localparam logic [7:0] C_MC   = 8'b00011_001;
  localparam logic [7:0] C_RED  = 8'b11111_110;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  state_t           r_state, w_next;
  logic [MCW-1:0]   r_mc_cnt, w_mc_cnt;
  logic             r_mc_done;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic [7:0]       w_ctl;
  logic             w_busy, w_redir, w_mem, w_load_use;
  assign w_mem = IM_busy | DM_busy;
  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((ID_EX_Rd == ID_Rs1 && ID_use_rs1) || (ID_EX_Rd == ID_Rs2 && ID_use_rs2));
  always_comb begin
    w_next   = r_state;
    w_mc_cnt = r_mc_cnt;
    w_ctl    = C_ALL;
    w_busy   = 1'b0;
    w_redir  = 1'b0;
    if (r_state == INIT) begin
      w_ctl  = C_INIT;
      w_next = RUN;
    end else if (w_mem) begin
      w_ctl  = 8'd0;
      w_busy = (r_state == MC_WAIT) && (r_mc_cnt != '0);
    end else if (r_state == MC_WAIT) begin
      // counter==0 is the release cycle: the op leaves EX and the pipe advances normally
      if (r_mc_cnt == '0) w_next = RUN;
      else begin
        w_ctl    = C_MC;
        w_busy   = 1'b1;
        w_mc_cnt = r_mc_cnt - 1'b1;
      end
    end else if (EX_mc_start && !r_mc_done) begin
      w_next   = MC_WAIT;
      w_mc_cnt = MCW'(MC_LAT - 2);
      w_ctl    = C_MC;
      w_busy   = 1'b1;
    end else if (EX_redirect) begin
      w_ctl   = C_RED;
      w_redir = 1'b1;
    end else if (w_load_use) begin
      w_ctl = C_LU;
    end
  end
  assign {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
          IF_ID_flush, ID_EX_flush, EX_MEM_flush} = w_ctl;
  assign mc_busy      = w_busy;
  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT;
      r_mc_cnt  <= '0;
      r_mc_done <= 1'b0;
      r_stall   <= '0;
      r_flush   <= '0;
    end else begin
      r_state   <= w_next;
      r_mc_cnt  <= w_mc_cnt;
      // the completed op's start level may linger one cycle; hold the flag while EX is frozen
      r_mc_done <= (w_mem && r_state != INIT) ? r_mc_done : (r_state == MC_WAIT && w_next == RUN);
      if (r_state != INIT && !w_ctl[7]) r_stall <= r_stall + CNT_W'(1);
      if (w_redir) r_flush <= r_flush + CNT_W'(1);
    end
  end
endmodule
